// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port cache-line memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY0   = 2'd1,
    BUSY1   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Command latched at grant time and held for the whole transaction.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } mem_cmd_t;

  // Returns 1 when port 1 should win; on a tie the port that did not win last time is chosen.
  function automatic logic pick_p1(input logic en0, input logic en1, input logic last_grant);
    if (en0 && en1) begin
      return !last_grant;
    end
    return en1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals of the arbiter, bundled with arbiter/environment views.
interface mem_arbiter_if;

  logic                                 p0_enable_i;
  logic                                 p0_write_i;
  logic [mem_arbiter_pkg::ADDR_W-1:0]   p0_addr_i;
  logic [mem_arbiter_pkg::LINE_W-1:0]   p0_data_i;
  logic [mem_arbiter_pkg::LINE_W-1:0]   p0_data_o;
  logic                                 p0_ack_o;

  logic                                 p1_enable_i;
  logic                                 p1_write_i;
  logic [mem_arbiter_pkg::ADDR_W-1:0]   p1_addr_i;
  logic [mem_arbiter_pkg::LINE_W-1:0]   p1_data_i;
  logic [mem_arbiter_pkg::LINE_W-1:0]   p1_data_o;
  logic                                 p1_ack_o;

  logic                                 mem_enable_o;
  logic                                 mem_write_o;
  logic [mem_arbiter_pkg::ADDR_W-1:0]   mem_addr_o;
  logic [mem_arbiter_pkg::LINE_W-1:0]   mem_data_o;
  logic [mem_arbiter_pkg::LINE_W-1:0]   mem_data_i;
  logic                                 mem_ack_i;

  logic                                 err_o;

  // Arbiter side.
  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p0_data_o, p0_ack_o,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output p1_data_o, p1_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i,
    output err_o
  );

  // Requester/memory environment side.
  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p0_data_o, p0_ack_o,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  p1_data_o, p1_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i,
    input  err_o
  );

endinterface

// File: rtl/arb_watchdog.sv
// Busy-cycle counter that flags a transaction which has waited TIMEOUT cycles without an ack.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear outside a transaction, count each busy cycle that lacks an ack.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is the cycle whose increment would bring the count to TIMEOUT.
  assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) round-robin arbiter in front of a single line-wide memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       err_q, err_d;
  mem_cmd_t   cmd_q, cmd_d;
  logic       grant_p1;
  logic       busy;
  logic       wd_expired;

  assign busy = (state_q == BUSY0) || (state_q == BUSY1);

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!busy),
    .enable_i  (busy && !bus.mem_ack_i),
    .expired_o (wd_expired)
  );

  // Next-state logic: arbitration in IDLE, completion or timeout in BUSYn.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    cmd_d        = cmd_q;
    grant_p1     = pick_p1(bus.p0_enable_i, bus.p1_enable_i, last_grant_q);
    case (state_q)
      IDLE: begin
        if (bus.p0_enable_i || bus.p1_enable_i) begin
          last_grant_d = grant_p1;
          if (grant_p1) begin
            cmd_d   = '{write: bus.p1_write_i, addr: bus.p1_addr_i, data: bus.p1_data_i};
            state_d = BUSY1;
          end else begin
            cmd_d   = '{write: bus.p0_write_i, addr: bus.p0_addr_i, data: bus.p0_data_i};
            state_d = BUSY0;
          end
        end
      end
      BUSY0, BUSY1: begin
        // An ack in the expiry cycle wins: the watchdog only fires without an ack.
        if (bus.mem_ack_i) begin
          state_d = RELEASE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant history, sticky error and latched command.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cmd_q        <= cmd_d;
    end
  end

  // Outputs decoded from state so a reset drops the memory request at once.
  always_comb begin
    bus.mem_enable_o = busy;
    bus.mem_write_o  = cmd_q.write;
    bus.mem_addr_o   = cmd_q.addr;
    bus.mem_data_o   = cmd_q.data;
    bus.p0_ack_o     = (state_q == BUSY0) && bus.mem_ack_i;
    bus.p1_ack_o     = (state_q == BUSY1) && bus.mem_ack_i;
    bus.p0_data_o    = (state_q == BUSY0) ? bus.mem_data_i : '0;
    bus.p1_data_o    = (state_q == BUSY1) ? bus.mem_data_i : '0;
    bus.err_o        = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written corner sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter dut_a (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_a)
  );

  mem_arbiter #(
    .TIMEOUT(8)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic        p0_en, p0_wr;
    logic [31:0] p0_addr, p0_data;
    logic        p1_en, p1_wr;
    logic [31:0] p1_addr, p1_data;
    logic        ack;
    logic [31:0] mdata;
    logic        e_en, e_wr;
    logic [31:0] e_addr, e_mdata;
    logic        e_ack0, e_ack1;
    logic [31:0] e_d0, e_d1;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(
    input logic p0e, input logic p0w, input logic [31:0] p0a, input logic [31:0] p0d,
    input logic p1e, input logic p1w, input logic [31:0] p1a, input logic [31:0] p1d,
    input logic ak, input logic [31:0] md,
    input logic ee, input logic ew, input logic [31:0] ea, input logic [31:0] emd,
    input logic a0, input logic a1, input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.p0_en = p0e; v.p0_wr = p0w; v.p0_addr = p0a; v.p0_data = p0d;
    v.p1_en = p1e; v.p1_wr = p1w; v.p1_addr = p1a; v.p1_data = p1d;
    v.ack = ak; v.mdata = md;
    v.e_en = ee; v.e_wr = ew; v.e_addr = ea; v.e_mdata = emd;
    v.e_ack0 = a0; v.e_ack1 = a1; v.e_d0 = d0; v.e_d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs_a();
    bus_a.p0_enable_i = 1'b0; bus_a.p0_write_i = 1'b0; bus_a.p0_addr_i = '0; bus_a.p0_data_i = '0;
    bus_a.p1_enable_i = 1'b0; bus_a.p1_write_i = 1'b0; bus_a.p1_addr_i = '0; bus_a.p1_data_i = '0;
    bus_a.mem_ack_i = 1'b0; bus_a.mem_data_i = '0;
  endtask

  task automatic idle_inputs_b();
    bus_b.p0_enable_i = 1'b0; bus_b.p0_write_i = 1'b0; bus_b.p0_addr_i = '0; bus_b.p0_data_i = '0;
    bus_b.p1_enable_i = 1'b0; bus_b.p1_write_i = 1'b0; bus_b.p1_addr_i = '0; bus_b.p1_data_i = '0;
    bus_b.mem_ack_i = 1'b0; bus_b.mem_data_i = '0;
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    logic [255:0] line_a5;
    line_a5 = {32{8'hA5}};
    idle_inputs_a();
    idle_inputs_b();

    vecs[0]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 0,32'h00, 0,0,32'h00,32'h0000, 0,0,32'h00,32'h00);
    vecs[1]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 0,32'h00, 1,0,32'h10,32'h00D0, 0,0,32'h00,32'h00);
    vecs[2]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 1,32'h55, 1,0,32'h10,32'h00D0, 1,0,32'h55,32'h00);
    vecs[3]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 0,32'h00, 0,0,32'h10,32'h00D0, 0,0,32'h00,32'h00);
    vecs[4]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 0,32'h00, 0,0,32'h10,32'h00D0, 0,0,32'h00,32'h00);
    vecs[5]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 0,32'h00, 1,0,32'h20,32'h00D1, 0,0,32'h00,32'h00);
    vecs[6]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 1,32'h66, 1,0,32'h20,32'h00D1, 0,1,32'h00,32'h66);
    vecs[7]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 0,32'h00, 0,0,32'h20,32'h00D1, 0,0,32'h00,32'h00);
    vecs[8]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 0,32'h00, 0,0,32'h20,32'h00D1, 0,0,32'h00,32'h00);
    vecs[9]  = mk(1,0,32'h10,32'hD0, 1,0,32'h20,32'hD1, 1,32'h77, 1,0,32'h10,32'h00D0, 1,0,32'h77,32'h00);
    vecs[10] = mk(0,0,32'h10,32'hD0, 0,0,32'h20,32'hD1, 1,32'h88, 0,0,32'h10,32'h00D0, 0,0,32'h00,32'h00);
    vecs[11] = mk(0,0,32'h00,32'h00, 0,0,32'h00,32'h00, 1,32'h99, 0,0,32'h10,32'h00D0, 0,0,32'h00,32'h00);
    vecs[12] = mk(0,0,32'h00,32'h00, 1,1,32'h200,32'h1234, 0,32'h00, 0,0,32'h10,32'h00D0, 0,0,32'h00,32'h00);
    vecs[13] = mk(0,0,32'h00,32'h00, 1,0,32'h300,32'h9999, 0,32'h00, 1,1,32'h200,32'h1234, 0,0,32'h00,32'h00);
    vecs[14] = mk(0,0,32'h00,32'h00, 0,0,32'h300,32'h9999, 0,32'h00, 1,1,32'h200,32'h1234, 0,0,32'h00,32'h00);
    vecs[15] = mk(0,0,32'h00,32'h00, 0,0,32'h300,32'h9999, 1,32'hAB, 1,1,32'h200,32'h1234, 0,1,32'h00,32'hAB);
    vecs[16] = mk(0,0,32'h00,32'h00, 0,0,32'h300,32'h9999, 0,32'h00, 0,1,32'h200,32'h1234, 0,0,32'h00,32'h00);
    vecs[17] = mk(0,0,32'h00,32'h00, 0,0,32'h300,32'h9999, 0,32'h00, 0,1,32'h200,32'h1234, 0,0,32'h00,32'h00);

    // Asynchronous reset: outputs must clear with no clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst mem_enable", bus_a.mem_enable_o, 0);
    chk("rst mem_write",  bus_a.mem_write_o, 0);
    chk("rst mem_addr",   bus_a.mem_addr_o, 0);
    chk("rst mem_data",   bus_a.mem_data_o, 0);
    chk("rst p0_ack",     bus_a.p0_ack_o, 0);
    chk("rst p1_ack",     bus_a.p1_ack_o, 0);
    chk("rst err_a",      bus_a.err_o, 0);
    chk("rst err_b",      bus_b.err_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table: arbitration/alternation, ignored acks, command hold, enable drop mid-BUSY.
    for (int i = 0; i < 18; i++) begin
      bus_a.p0_enable_i = vecs[i].p0_en;
      bus_a.p0_write_i  = vecs[i].p0_wr;
      bus_a.p0_addr_i   = vecs[i].p0_addr;
      bus_a.p0_data_i   = {224'h0, vecs[i].p0_data};
      bus_a.p1_enable_i = vecs[i].p1_en;
      bus_a.p1_write_i  = vecs[i].p1_wr;
      bus_a.p1_addr_i   = vecs[i].p1_addr;
      bus_a.p1_data_i   = {224'h0, vecs[i].p1_data};
      bus_a.mem_ack_i   = vecs[i].ack;
      bus_a.mem_data_i  = {224'h0, vecs[i].mdata};
      @(negedge clk);
      chk($sformatf("v%0d mem_enable", i), bus_a.mem_enable_o, vecs[i].e_en);
      chk($sformatf("v%0d mem_write", i),  bus_a.mem_write_o, vecs[i].e_wr);
      chk($sformatf("v%0d mem_addr", i),   bus_a.mem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d mem_data", i),   bus_a.mem_data_o, {224'h0, vecs[i].e_mdata});
      chk($sformatf("v%0d p0_ack", i),     bus_a.p0_ack_o, vecs[i].e_ack0);
      chk($sformatf("v%0d p1_ack", i),     bus_a.p1_ack_o, vecs[i].e_ack1);
      chk($sformatf("v%0d p0_data", i),    bus_a.p0_data_o, {224'h0, vecs[i].e_d0});
      chk($sformatf("v%0d p1_data", i),    bus_a.p1_data_o, {224'h0, vecs[i].e_d1});
      tick();
    end
    idle_inputs_a();

    // p0 read at 0x100 with the memory acking in its 10th busy cycle.
    bus_a.p0_enable_i = 1'b1;
    bus_a.p0_addr_i   = 32'h100;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus_a.mem_ack_i  = (i == 9);
      bus_a.mem_data_i = (i == 9) ? line_a5 : '0;
      @(negedge clk);
      chk($sformatf("rd100 c%0d mem_enable", i), bus_a.mem_enable_o, 1);
      chk($sformatf("rd100 c%0d p0_ack", i), bus_a.p0_ack_o, (i == 9));
      if (i == 9) begin
        chk("rd100 p0_data", bus_a.p0_data_o, line_a5);
        chk("rd100 mem_addr", bus_a.mem_addr_o, 32'h100);
      end
      tick();
    end
    idle_inputs_a();
    @(negedge clk);
    chk("rd100 release mem_enable", bus_a.mem_enable_o, 0);
    chk("rd100 release p0_ack", bus_a.p0_ack_o, 0);
    tick();
    @(negedge clk);
    chk("rd100 idle mem_enable", bus_a.mem_enable_o, 0);
    tick();

    // Reset during BUSY1, then a stray ack two cycles later.
    bus_a.p1_enable_i = 1'b1;
    bus_a.p1_write_i  = 1'b1;
    bus_a.p1_addr_i   = 32'h40;
    bus_a.p1_data_i   = {224'h0, 32'h5};
    tick();
    @(negedge clk);
    chk("rstbusy pre mem_enable", bus_a.mem_enable_o, 1);
    chk("rstbusy pre mem_addr", bus_a.mem_addr_o, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("rstbusy mem_enable", bus_a.mem_enable_o, 0);
    chk("rstbusy mem_write", bus_a.mem_write_o, 0);
    chk("rstbusy mem_addr", bus_a.mem_addr_o, 0);
    chk("rstbusy mem_data", bus_a.mem_data_o, 0);
    chk("rstbusy p1_ack", bus_a.p1_ack_o, 0);
    idle_inputs_a();
    #1 rst_n = 1'b1;
    tick();
    tick();
    bus_a.mem_ack_i  = 1'b1;
    bus_a.mem_data_i = line_a5;
    @(negedge clk);
    chk("late ack p1_ack", bus_a.p1_ack_o, 0);
    chk("late ack p0_ack", bus_a.p0_ack_o, 0);
    chk("late ack p1_data", bus_a.p1_data_o, 0);
    chk("late ack mem_enable", bus_a.mem_enable_o, 0);
    tick();
    bus_a.mem_ack_i = 1'b0;

    // After reset a tie goes to p0 again.
    bus_a.p0_enable_i = 1'b1;
    bus_a.p0_addr_i   = 32'h500;
    bus_a.p1_enable_i = 1'b1;
    bus_a.p1_addr_i   = 32'h600;
    tick();
    bus_a.mem_ack_i = 1'b1;
    @(negedge clk);
    chk("tie after rst mem_addr", bus_a.mem_addr_o, 32'h500);
    chk("tie after rst p0_ack", bus_a.p0_ack_o, 1);
    chk("tie after rst p1_ack", bus_a.p1_ack_o, 0);
    tick();
    idle_inputs_a();
    tick();
    tick();

    // TIMEOUT=8: ack in the 8th busy cycle is still a success.
    bus_b.p0_enable_i = 1'b1;
    bus_b.p0_addr_i   = 32'h700;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus_b.mem_ack_i  = (i == 7);
      bus_b.mem_data_i = {224'h0, 32'h3C};
      @(negedge clk);
      chk($sformatf("edge c%0d mem_enable", i), bus_b.mem_enable_o, 1);
      chk($sformatf("edge c%0d p0_ack", i), bus_b.p0_ack_o, (i == 7));
      tick();
    end
    idle_inputs_b();
    @(negedge clk);
    chk("edge release mem_enable", bus_b.mem_enable_o, 0);
    chk("edge err", bus_b.err_o, 0);
    tick();
    tick();

    // TIMEOUT=8 with no ack: 8 busy cycles, then err and release.
    bus_b.p0_enable_i = 1'b1;
    bus_b.p0_addr_i   = 32'h700;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("tmo c%0d mem_enable", i), bus_b.mem_enable_o, 1);
      chk($sformatf("tmo c%0d p0_ack", i), bus_b.p0_ack_o, 0);
      chk($sformatf("tmo c%0d err", i), bus_b.err_o, 0);
      tick();
    end
    idle_inputs_b();
    @(negedge clk);
    chk("tmo release mem_enable", bus_b.mem_enable_o, 0);
    chk("tmo release err", bus_b.err_o, 1);
    chk("tmo release p0_ack", bus_b.p0_ack_o, 0);
    tick();
    @(negedge clk);
    chk("tmo idle mem_enable", bus_b.mem_enable_o, 0);
    tick();

    // Following request still served; err stays set.
    bus_b.p1_enable_i = 1'b1;
    bus_b.p1_addr_i   = 32'h800;
    tick();
    bus_b.mem_ack_i  = 1'b1;
    bus_b.mem_data_i = {224'h0, 32'h11};
    @(negedge clk);
    chk("post tmo mem_addr", bus_b.mem_addr_o, 32'h800);
    chk("post tmo p1_ack", bus_b.p1_ack_o, 1);
    chk("post tmo p1_data", bus_b.p1_data_o, 32'h11);
    chk("post tmo err", bus_b.err_o, 1);
    tick();
    idle_inputs_b();
    @(negedge clk);
    chk("post tmo release mem_enable", bus_b.mem_enable_o, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: cycles to wait for mem_ack_i before aborting a transaction.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports p0_enable_i / p1_enable_i, input, 1 each: request level (p0 = instruction cache, p1 = data cache).
REQ-005 SHALL have ports p0_write_i / p1_write_i, input, 1 each: 1 = write line, 0 = read line.
REQ-006 SHALL have ports p0_addr_i / p1_addr_i, input, 32 each: line byte address.
REQ-007 SHALL have ports p0_data_i / p1_data_i, input, 256 each: write line data.
REQ-008 SHALL have ports p0_data_o / p1_data_o, output, 256 each: read line data.
REQ-009 SHALL have ports p0_ack_o / p1_ack_o, output, 1 each: transaction-complete pulse.
REQ-010 SHALL have port mem_enable_o, output, 1: memory request level.
REQ-011 SHALL have port mem_write_o, output, 1: memory write select.
REQ-012 SHALL have port mem_addr_o, output, 32: memory address.
REQ-013 SHALL have port mem_data_o, output, 256: memory write data.
REQ-014 SHALL have port mem_data_i, input, 256: memory read data.
REQ-015 SHALL have port mem_ack_i, input, 1: memory completion, one cycle high.
REQ-016 SHALL have port err_o, output, 1: sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY0, BUSY1, RELEASE.
REQ-018 IDLE: one enable high -> grant that port; both high -> grant port != last_grant; none high -> stay in IDLE.
REQ-019 On grant, SHALL register the winner's write/addr/data into mem_write_o/mem_addr_o/mem_data_o, set last_grant, and enter BUSYn on the next edge.
REQ-020 BUSYn: mem_enable_o = 1 and the registered command SHALL stay stable; requester input changes are ignored.
REQ-021 BUSYn with mem_ack_i = 1: pn_ack_o = 1 combinationally in that cycle, pn_data_o = mem_data_i; next state RELEASE.
REQ-022 pn_data_o SHALL be mem_data_i when pn is granted, otherwise 0; the ungranted port's ack SHALL be 0.
REQ-023 RELEASE lasts exactly one cycle with mem_enable_o = 0 (lets requester drop enable), then IDLE.
REQ-024 Back-to-back requests SHALL give a grant-to-grant spacing of at least 3 cycles plus memory latency; neither port can starve while the other holds enable (strict alternation).
REQ-025 Requester dropping enable during BUSYn SHALL NOT abort: transaction completes and ack still pulses.
REQ-026 Watchdog counter (width clog2(TIMEOUT+1)) SHALL clear on entry to BUSYn and increment each BUSY cycle without ack; at TIMEOUT: err_o <= 1, no ack, mem_enable_o drops, next state RELEASE.
REQ-027 mem_ack_i outside BUSYn SHALL be ignored.
REQ-028 Ack in the same cycle the counter reaches TIMEOUT SHALL count as success: ack given, err_o unchanged.

Reset
REQ-029 On rst_i = 0 (async): state = IDLE, last_grant = 1 (so p0 wins first tie), counter = 0, err_o = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, both acks 0.
REQ-030 Reset mid-transaction SHALL drop mem_enable_o immediately with no ack; a late mem_ack_i after release is ignored by REQ-027.

Structure
REQ-031 Shared package SHALL hold the state encoding (IDLE=0, BUSY0=1, BUSY1=2, RELEASE=3), LINE_W = 256, and ADDR_W = 32.
REQ-032 SHALL be a single module; the watchdog MAY be the sub-module arb_watchdog (clear, enable, expired).

Verification
REQ-033 p0 read at addr 0x100; memory acks after 10 cycles with data 0xA5..A5 -> p0_ack_o high one cycle, p0_data_o = 0xA5..A5, mem_enable_o high 10 cycles then RELEASE.
REQ-034 p0 and p1 high in the same cycle after reset -> p0 served first, then p1; with both kept high, grants alternate p0, p1, p0.
REQ-035 p1 write to 0x200, data 0x1234; p1 changes addr to 0x300 mid-BUSY -> mem_addr_o stays 0x200 and mem_data_o stays 0x1234 until ack.
REQ-036 Memory never acks, TIMEOUT = 8 -> err_o rises after 8 BUSY cycles, no ack, then RELEASE, IDLE; next request is still served.
REQ-037 rst_i driven low during BUSY1 -> all outputs reset the same cycle; an ack 2 cycles later produces no port ack.
